// File: rtl/spi_sched_pkg.sv
// Shared sizing for the SPI frame scheduler: default geometry and derived pointer widths.
package spi_sched_pkg;

   localparam int DEF_N_SRC       = 4;
   localparam int DEF_FRAME_BYTES = 16;
   localparam int DEF_DATA_W      = 8;
   localparam int SLOT_BYTES      = DEF_FRAME_BYTES / DEF_N_SRC;
   localparam int PTR_W           = $clog2(DEF_FRAME_BYTES);
   localparam int SLOT_PTR_W      = (SLOT_BYTES > 1) ? $clog2(SLOT_BYTES) : 1;

endpackage

// File: rtl/spi_frame_scheduler_rr_arbiter.sv
// N-way round-robin arbiter: one-hot grant among req, priority rotates past the last winner.
import spi_sched_pkg::*;

module rr_arbiter #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] req,
   input  logic         advance,
   output logic [N-1:0] grant
);

   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

   logic [IDX_W-1:0] ptr_r;
   logic [IDX_W-1:0] gidx_s;
   logic [IDX_W-1:0] idx_s;
   logic             found_s;
   logic             hit_s;

   // Scan requesters starting at the priority pointer; first hit wins.
   always_comb begin
      grant   = '0;
      gidx_s  = '0;
      found_s = 1'b0;
      idx_s   = '0;
      hit_s   = 1'b0;
      for (int k = 0; k < N; k++) begin
         idx_s        = ptr_r + IDX_W'(k);
         hit_s        = ~found_s & req[idx_s];
         grant[idx_s] = grant[idx_s] | hit_s;
         gidx_s       = hit_s ? idx_s : gidx_s;
         found_s      = found_s | hit_s;
      end
   end

   // Priority pointer moves just past the winner after a transfer.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr_r <= '0;
      end else if (advance && found_s) begin
         ptr_r <= gidx_s + IDX_W'(1);
      end
   end

endmodule

// File: rtl/spi_frame_scheduler.sv
// Double-buffered telemetry frame: producers fill staging slots, a commit swaps banks
// between SPI transactions, and the shifter reads the live bank byte by byte.
import spi_sched_pkg::*;

module spi_frame_scheduler #(
   parameter int N_SRC       = DEF_N_SRC,
   parameter int FRAME_BYTES = DEF_FRAME_BYTES,
   parameter int DATA_W      = DEF_DATA_W
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [N_SRC-1:0]        src_valid,
   input  logic [N_SRC*DATA_W-1:0] src_data,
   output logic [N_SRC-1:0]        src_ready,
   input  logic                    spi_ss_active,
   input  logic                    spi_start,
   input  logic                    spi_byte_req,
   output logic [DATA_W-1:0]       spi_tx_byte,
   output logic [7:0]              frame_seq,
   output logic                    frame_stale
);

   localparam int SLOT_N = FRAME_BYTES / N_SRC;
   localparam int RD_W   = $clog2(FRAME_BYTES);
   localparam int WP_W   = (SLOT_N > 1) ? $clog2(SLOT_N) : 1;

   logic [DATA_W-1:0] bank_r [2][FRAME_BYTES];
   logic              bank_sel_r;
   logic [WP_W-1:0]   wp_r [N_SRC];
   logic [N_SRC-1:0]  done_r;
   logic [RD_W-1:0]   rd_ptr_r;
   logic              fresh_r;
   logic              swap_s;
   logic [N_SRC-1:0]  eligible_s;
   logic [N_SRC-1:0]  grant_s;

   // Commit only between transactions; producers are frozen during the swap cycle.
   assign swap_s     = (&done_r) & ~spi_ss_active & ~spi_start;
   assign eligible_s = src_valid & ~done_r & {N_SRC{~swap_s & rst_n}};
   assign src_ready  = grant_s;

   rr_arbiter #(
      .N (N_SRC)
   ) u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (eligible_s),
      .advance (|grant_s),
      .grant   (grant_s)
   );

   // Staging writes, slot bookkeeping and the atomic bank swap.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int b = 0; b < 2; b++) begin
            for (int j = 0; j < FRAME_BYTES; j++) begin
               bank_r[b][j] <= '0;
            end
         end
         for (int i = 0; i < N_SRC; i++) begin
            wp_r[i] <= '0;
         end
         done_r     <= '0;
         bank_sel_r <= 1'b0;
         frame_seq  <= 8'd0;
         fresh_r    <= 1'b0;
      end else if (swap_s) begin
         bank_sel_r <= ~bank_sel_r;
         done_r     <= '0;
         frame_seq  <= frame_seq + 8'd1;
         fresh_r    <= 1'b1;
      end else begin
         if (spi_start) begin
            fresh_r <= 1'b0;
         end
         for (int i = 0; i < N_SRC; i++) begin
            if (grant_s[i]) begin
               bank_r[~bank_sel_r][RD_W'(i * SLOT_N) + RD_W'(wp_r[i])] <= src_data[i*DATA_W +: DATA_W];
               if (wp_r[i] == WP_W'(SLOT_N - 1)) begin
                  wp_r[i]   <= '0;
                  done_r[i] <= 1'b1;
               end else begin
                  wp_r[i] <= wp_r[i] + WP_W'(1);
               end
            end
         end
      end
   end

   // Live-bank read port for the shifter; a start always restarts at byte 0.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         spi_tx_byte <= '0;
         rd_ptr_r    <= '0;
         frame_stale <= 1'b0;
      end else if (spi_start) begin
         spi_tx_byte <= bank_r[bank_sel_r][0];
         rd_ptr_r    <= RD_W'(1);
         frame_stale <= ~fresh_r;
      end else if (spi_byte_req && spi_ss_active) begin
         spi_tx_byte <= bank_r[bank_sel_r][rd_ptr_r];
         rd_ptr_r    <= rd_ptr_r + RD_W'(1);
      end
   end

endmodule

// File: tb/tb_spi_frame_scheduler.sv
// Self-checking bench: constant vector table, directed corner sequences and a random
// phase, all compared against a frame-level reference model.
module tb_spi_frame_scheduler;

   localparam int N    = 4;
   localparam int FB   = 16;
   localparam int SLOT = FB / N;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [N-1:0]   src_valid;
   logic [N*8-1:0] src_data;
   logic [N-1:0]   src_ready;
   logic           ss, start, req;
   logic [7:0]     tx, seq;
   logic           stale;

   always #5 clk = ~clk;

   spi_frame_scheduler #(.N_SRC(N), .FRAME_BYTES(FB), .DATA_W(8)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .src_valid     (src_valid),
      .src_data      (src_data),
      .src_ready     (src_ready),
      .spi_ss_active (ss),
      .spi_start     (start),
      .spi_byte_req  (req),
      .spi_tx_byte   (tx),
      .frame_seq     (seq),
      .frame_stale   (stale)
   );

   int tests = 0;
   int fails = 0;
   logic [N-1:0] last_ready;

   // Reference model: staged and live frames as byte arrays, fill counts per producer.
   logic [7:0] m_stage [FB];
   logic [7:0] m_live  [FB];
   int         m_cnt   [N];
   bit         m_done  [N];
   int         m_ptr, m_seq, m_rd;
   bit         m_fresh, m_stale;
   logic [7:0] m_tx;

   typedef struct {
      logic       r;
      logic       s;
      logic       st;
      logic       rq;
      logic [7:0] exp_tx;
      logic [7:0] exp_seq;
      logic       exp_stale;
   } vec_t;
   vec_t tbl [18];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int j = 0; j < FB; j++) begin
         m_stage[j] = 8'h00;
         m_live[j]  = 8'h00;
      end
      for (int i = 0; i < N; i++) begin
         m_cnt[i]  = 0;
         m_done[i] = 1'b0;
      end
      m_ptr = 0; m_seq = 0; m_rd = 0;
      m_fresh = 1'b0; m_stale = 1'b0; m_tx = 8'h00;
   endtask

   function automatic bit all_done();
      bit a = 1'b1;
      for (int i = 0; i < N; i++) a &= m_done[i];
      return a;
   endfunction

   function automatic logic [N-1:0] model_ready();
      if (!rst_n || (all_done() && !ss && !start)) return '0;
      for (int k = 0; k < N; k++) begin
         int i;
         i = (m_ptr + k) % N;
         if (src_valid[i] && !m_done[i]) return N'(1) << i;
      end
      return '0;
   endfunction

   task automatic model_update(input logic [N-1:0] g);
      bit swap;
      if (!rst_n) begin
         model_reset();
         return;
      end
      swap = all_done() && !ss && !start;
      if (start) begin
         m_tx = m_live[0]; m_rd = 1; m_stale = !m_fresh; m_fresh = 1'b0;
      end else if (req && ss) begin
         m_tx = m_live[m_rd]; m_rd = (m_rd + 1) % FB;
      end
      if (swap) begin
         m_live = m_stage;
         for (int i = 0; i < N; i++) m_done[i] = 1'b0;
         m_seq = (m_seq + 1) % 256;
         m_fresh = 1'b1;
      end else begin
         for (int i = 0; i < N; i++) begin
            if (g[i]) begin
               m_stage[i*SLOT + m_cnt[i]] = src_data[i*8 +: 8];
               m_cnt[i]++;
               if (m_cnt[i] == SLOT) begin
                  m_cnt[i] = 0; m_done[i] = 1'b1;
               end
               m_ptr = (i + 1) % N;
            end
         end
      end
   endtask

   // One clock: check ready before the edge, advance the model, check registered outputs.
   task automatic cyc();
      logic [N-1:0] er;
      #1;
      er = model_ready();
      last_ready = src_ready;
      check("src_ready", src_ready, er);
      @(posedge clk);
      model_update(er);
      #1;
      check("spi_tx_byte", tx, m_tx);
      check("frame_seq", seq, m_seq);
      check("frame_stale", stale, m_stale);
   endtask

   task automatic drive(input logic r, input logic [N-1:0] v, input logic s,
                        input logic st, input logic rq);
      rst_n = r; src_valid = v; ss = s; start = st; req = rq;
   endtask

   function automatic logic [7:0] pat(input int j);
      return 8'(16 * (j / 4) + (j % 4));
   endfunction

   task automatic fill(input int p, input logic [7:0] base);
      for (int k = 0; k < SLOT; k++) begin
         src_valid = N'(1) << p;
         src_data[p*8 +: 8] = base + 8'(k);
         cyc();
         check("fill_ready", last_ready, N'(1) << p);
      end
      src_valid = '0;
   endtask

   initial begin
      model_reset();
      src_data = '0;
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0);

      // Vector table: reset, then a start and 16 byte requests on the all-zero frame.
      tbl[0] = '{r: 1'b0, s: 1'b0, st: 1'b0, rq: 1'b0, exp_tx: 8'h00, exp_seq: 8'h00, exp_stale: 1'b0};
      tbl[1] = '{r: 1'b1, s: 1'b1, st: 1'b1, rq: 1'b0, exp_tx: 8'h00, exp_seq: 8'h00, exp_stale: 1'b1};
      for (int j = 2; j < 18; j++)
         tbl[j] = '{r: 1'b1, s: 1'b1, st: 1'b0, rq: 1'b1, exp_tx: 8'h00, exp_seq: 8'h00, exp_stale: 1'b1};
      for (int j = 0; j < 18; j++) begin
         drive(tbl[j].r, '0, tbl[j].s, tbl[j].st, tbl[j].rq);
         cyc();
         check("tbl_tx", tx, tbl[j].exp_tx);
         check("tbl_seq", seq, tbl[j].exp_seq);
         check("tbl_stale", stale, tbl[j].exp_stale);
         check("tbl_ready", last_ready, '0);
      end

      // Slot-ordered fill with SS idle, then read 20 bytes and a start coincident with a request.
      drive(1'b1, '0, 1'b0, 1'b0, 1'b0);
      for (int p = 0; p < N; p++) fill(p, 8'(16 * p));
      cyc();
      check("commit_seq1", seq, 8'd1);
      drive(1'b1, '0, 1'b1, 1'b1, 1'b0);
      cyc();
      check("t2_first", tx, 8'h00);
      check("t2_fresh", stale, 1'b0);
      for (int j = 1; j < 20; j++) begin
         drive(1'b1, '0, 1'b1, 1'b0, 1'b1);
         cyc();
         check("t2_byte", tx, pat(j % FB));
      end
      drive(1'b1, '0, 1'b1, 1'b1, 1'b1);
      cyc();
      check("start_wins", tx, 8'h00);
      check("reread_stale", stale, 1'b1);

      // All producers valid: grants rotate 0,1,2,3; swap cycle accepts nothing.
      drive(1'b1, '1, 1'b0, 1'b0, 1'b0);
      for (int c = 0; c < 16; c++) begin
         src_data = $urandom;
         cyc();
         check("rotate", last_ready, N'(1) << (c % 4));
      end
      cyc();
      check("swap_no_ready", last_ready, '0);
      check("commit_seq2", seq, 8'd2);

      // Fill completes while SS is active: commit waits for SS to drop, exactly once.
      drive(1'b1, '0, 1'b1, 1'b1, 1'b0);
      cyc();
      start = 1'b0;
      fill(0, 8'hC0);
      src_valid = '1;
      for (int c = 0; c < 12; c++) begin
         src_data = $urandom;
         req = c[0];
         cyc();
         check("skip_done", last_ready, N'(1) << (1 + c % 3));
      end
      for (int c = 0; c < 3; c++) begin
         req = 1'b1;
         cyc();
         check("deferred_ready", last_ready, '0);
         check("deferred_seq", seq, 8'd2);
      end
      drive(1'b1, '0, 1'b0, 1'b0, 1'b0);
      cyc();
      check("late_commit", seq, 8'd3);
      cyc();
      cyc();
      check("single_commit", seq, 8'd3);

      // Random traffic against the model.
      for (int c = 0; c < 1500; c++) begin
         src_valid = N'($urandom);
         src_data  = $urandom;
         if ($urandom_range(0, 15) == 0) ss = ~ss;
         start = ($urandom_range(0, 19) == 0);
         req   = ss & $urandom_range(0, 1) == 1;
         cyc();
      end

      // Reset mid-fill discards partial slots; a complete new fill is required to commit.
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
      cyc();
      drive(1'b1, '0, 1'b0, 1'b0, 1'b0);
      fill(0, 8'h50);
      fill(1, 8'h60);
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
      cyc();
      check("rst_seq", seq, 8'd0);
      check("rst_tx", tx, 8'h00);
      drive(1'b1, '0, 1'b1, 1'b1, 1'b0);
      cyc();
      check("rst_read", tx, 8'h00);
      check("rst_stale", stale, 1'b1);
      drive(1'b1, '0, 1'b0, 1'b0, 1'b0);
      fill(2, 8'hA0);
      fill(3, 8'hB0);
      for (int c = 0; c < 3; c++) begin
         cyc();
         check("no_commit", seq, 8'd0);
      end
      fill(0, 8'h80);
      fill(1, 8'h90);
      cyc();
      check("restart_seq", seq, 8'd1);
      drive(1'b1, '0, 1'b1, 1'b1, 1'b0);
      cyc();
      check("new_frame_b0", tx, 8'h80);
      drive(1'b1, '0, 1'b1, 1'b0, 1'b1);
      for (int j = 1; j < 16; j++) cyc();
      check("new_frame_b15", tx, 8'hB3);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
